// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI4-Lite master state type and response codes
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } axi_mst_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Exclusive-okay is a success for a single-beat master that never issues exclusives.
  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:   return 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
      default:                          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/axi_watchdog.sv
// rtl/axi_watchdog.sv - busy-cycle watchdog for axi_lite_master (AXI_MASTER_TIMEOUT_EN)
module axi_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic AXI_ACLK,
  input  logic AXI_ARESET,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Count is 0 in the first busy cycle, so expiry lands on the last of TIMEOUT_CYCLES busy cycles.
  assign expired = busy && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET || clear) begin
      count <= '0;
    end else if (busy && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator for core load/store requests
// Optional watchdog abort enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_pkg::*;
#(
  parameter int AXI_AWIDTH     = 32,
  parameter int AXI_DWIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AXI_AWIDTH-1:0]   req_addr,
  input  logic [AXI_DWIDTH-1:0]   req_wdata,
  input  logic [AXI_DWIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  output logic [AXI_DWIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  axi_mst_state_t state, state_next;

  logic aw_done, w_done;
  logic accept, busy;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_complete, rd_complete, timeout, finish;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  assign aw_hs = AXI_AWVALID && AXI_AWREADY;
  assign w_hs  = AXI_WVALID  && AXI_WREADY;
  assign b_hs  = AXI_BVALID  && AXI_BREADY;
  assign ar_hs = AXI_ARVALID && AXI_ARREADY;
  assign r_hs  = AXI_RVALID  && AXI_RREADY;

  // Handshakes landing in the same cycle count as done alongside the sticky flags.
  assign wr_complete = (state == WRITE) && (aw_done || aw_hs) && (w_done || w_hs) && b_hs;
  assign rd_complete = (state == READ) && r_hs;
  assign finish      = wr_complete || rd_complete || timeout;

`ifdef AXI_MASTER_TIMEOUT_EN
  axi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .AXI_ACLK  (AXI_ACLK),
    .AXI_ARESET(AXI_ARESET),
    .clear     (accept),
    .busy      (busy),
    .expired   (timeout)
  );
`else
  // Without the watchdog the limit is meaningless; the comparison folds to a constant 0.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_we ? WRITE : READ;
      WRITE:   if (finish) state_next = IDLE;
      READ:    if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      AXI_AWADDR  <= '0;
      AXI_WDATA   <= '0;
      AXI_WSTRB   <= '0;
      AXI_ARADDR  <= '0;
      AXI_AWVALID <= 1'b0;
      AXI_WVALID  <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_ARVALID <= 1'b0;
      AXI_RREADY  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        if (req_we) begin
          AXI_AWADDR  <= req_addr;
          AXI_WDATA   <= req_wdata;
          AXI_WSTRB   <= req_wstrb;
          AXI_AWVALID <= 1'b1;
          AXI_WVALID  <= 1'b1;
          AXI_BREADY  <= 1'b1;
        end else begin
          AXI_ARADDR  <= req_addr;
          AXI_ARVALID <= 1'b1;
          AXI_RREADY  <= 1'b1;
        end
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (finish) begin
        AXI_AWVALID <= 1'b0;
        AXI_WVALID  <= 1'b0;
        AXI_BREADY  <= 1'b0;
        AXI_ARVALID <= 1'b0;
        AXI_RREADY  <= 1'b0;
        resp_valid  <= 1'b1;
        if (wr_complete) begin
          resp_err <= resp_is_err(AXI_BRESP);
        end else if (rd_complete) begin
          resp_err   <= resp_is_err(AXI_RRESP);
          resp_rdata <= AXI_RDATA;
        end else begin
          resp_err <= 1'b1;
        end
      end else begin
        if (aw_hs) begin
          AXI_AWVALID <= 1'b0;
          aw_done     <= 1'b1;
        end
        if (w_hs) begin
          AXI_WVALID <= 1'b0;
          w_done     <= 1'b1;
        end
        if (ar_hs) begin
          AXI_ARVALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - randomized self-checking bench for axi_lite_master
// Timeout scenarios run only when AXI_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master;

  localparam int TMO = 8;
  localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;

  logic        AXI_ACLK;
  logic        AXI_ARESET;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic [1:0]  AXI_BRESP, AXI_RRESP;
  logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] bus_mem [8];
  logic [31:0] ref_mem [8];
  logic [31:0] last_rdata = 32'h0;

  axi_lite_master #(
    .AXI_AWIDTH(32),
    .AXI_DWIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESET(AXI_ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  initial AXI_ACLK = 1'b0;
  always #5 AXI_ACLK = ~AXI_ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic next_cycle();
    @(posedge AXI_ACLK);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Called at posedge+1 of the request cycle (cycle 0); returns at posedge+1 after resp_valid.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_c, input int w_c, input int b_c, input logic [1:0] br);
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_strb;
    bit err;
    err = (br == 2'b10) || (br == 2'b11);
    cap_addr = 32'h0; cap_data = 32'h0; cap_strb = 4'h0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    @(negedge AXI_ACLK);
    check("wr_accept_ready", req_ready, 1'b1);
    check("resp_pulse_width", resp_valid, 1'b0);
    next_cycle();
    req_valid = 1'b0;
    for (int c = 1; c <= b_c + 1; c++) begin
      AXI_AWREADY = (c == aw_c);
      AXI_WREADY  = (c == w_c);
      AXI_BVALID  = (c == b_c);
      AXI_BRESP   = (c == b_c) ? br : 2'b00;
      @(negedge AXI_ACLK);
      check("awvalid", AXI_AWVALID, c <= aw_c);
      check("wvalid", AXI_WVALID, c <= w_c);
      check("bready", AXI_BREADY, c <= b_c);
      check("wr_resp_valid", resp_valid, c == b_c + 1);
      check("wr_req_ready", req_ready, c == b_c + 1);
      if (c == aw_c) begin
        cap_addr = AXI_AWADDR;
        check("awaddr", AXI_AWADDR, a);
      end
      if (c == w_c) begin
        cap_data = AXI_WDATA;
        cap_strb = AXI_WSTRB;
        check("wdata", AXI_WDATA, d);
        check("wstrb", {28'h0, AXI_WSTRB}, {28'h0, s});
      end
      if (c == b_c && !err) bus_mem[cap_addr[4:2]] = merge(bus_mem[cap_addr[4:2]], cap_data, cap_strb);
      if (c == b_c + 1) begin
        check("wr_resp_err", resp_err, err);
        check("wr_rdata_hold", resp_rdata, last_rdata);
      end
      next_cycle();
    end
    if (!err) ref_mem[a[4:2]] = merge(ref_mem[a[4:2]], d, s);
  endtask

  task automatic do_read(input logic [31:0] a, input int ar_c, input int r_c, input logic [1:0] rr);
    bit err, to;
    int last;
    logic [31:0] exp_data;
    err  = (rr == 2'b10) || (rr == 2'b11);
    last = r_c;
    to   = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
    if (r_c > TMO) begin
      last = TMO;
      to   = 1'b1;
    end
`endif
    exp_data = to ? last_rdata : (err ? ERR_DATA : ref_mem[a[4:2]]);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom; req_wstrb = 4'($urandom_range(0, 15));
    @(negedge AXI_ACLK);
    check("rd_accept_ready", req_ready, 1'b1);
    check("resp_pulse_width", resp_valid, 1'b0);
    next_cycle();
    req_valid = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      AXI_ARREADY = (c == ar_c);
      AXI_RVALID  = (c == r_c);
      AXI_RRESP   = (c == r_c) ? rr : 2'b00;
      AXI_RDATA   = (c == r_c) ? (err ? ERR_DATA : bus_mem[AXI_ARADDR[4:2]]) : $urandom;
      @(negedge AXI_ACLK);
      check("arvalid", AXI_ARVALID, (c <= ar_c) && (c <= last));
      check("rready", AXI_RREADY, c <= last);
      check("rd_awvalid_idle", AXI_AWVALID, 1'b0);
      check("rd_resp_valid", resp_valid, c == last + 1);
      check("rd_req_ready", req_ready, c == last + 1);
      if (c == ar_c) check("araddr", AXI_ARADDR, a);
      if (c == last + 1) begin
        check("rd_resp_err", resp_err, err || to);
        check("rd_rdata", resp_rdata, exp_data);
      end
      next_cycle();
    end
    AXI_ARREADY = 1'b0;
    AXI_RVALID  = 1'b0;
    last_rdata  = exp_data;
  endtask

  initial begin
    AXI_ARESET = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_BRESP = 2'b00; AXI_BVALID = 1'b0;
    AXI_ARREADY = 1'b0; AXI_RDATA = '0; AXI_RRESP = 2'b00; AXI_RVALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_mem[i] = 32'hA5A5_0000 + 32'(i);
      ref_mem[i] = 32'hA5A5_0000 + 32'(i);
    end

    repeat (3) @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    check("rst_awvalid", AXI_AWVALID, 1'b0);
    check("rst_wvalid", AXI_WVALID, 1'b0);
    check("rst_bready", AXI_BREADY, 1'b0);
    check("rst_arvalid", AXI_ARVALID, 1'b0);
    check("rst_rready", AXI_RREADY, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_awaddr", AXI_AWADDR, 32'h0);
    check("rst_araddr", AXI_ARADDR, 32'h0);
    check("rst_wdata", AXI_WDATA, 32'h0);
    check("rst_wstrb", {28'h0, AXI_WSTRB}, 32'h0);
    check("rst_req_ready", req_ready, 1'b1);
    next_cycle();
    AXI_ARESET = 1'b0;
    next_cycle();

    // memory-responder timing: READY/BVALID/RVALID in cycle 2, resp_valid in cycle 3
    do_write(32'h4, 32'hCAFE_BABE, 4'hF, 2, 2, 2, 2'b00);
    do_read(32'h4, 2, 2, 2'b00);
    check("wr_rd_cafebabe", resp_rdata, 32'hCAFE_BABE);

    bus_mem[2] = 32'h1122_3344;
    ref_mem[2] = 32'h1122_3344;
    do_write(32'h8, 32'h0000_AA00, 4'h2, 2, 2, 2, 2'b00);
    do_read(32'h8, 2, 2, 2'b00);
    check("partial_write", resp_rdata, 32'h1122_AA44);

    do_write(32'h14, 32'h1357_9BDF, 4'hF, 1, 4, 6, 2'b00);
    do_read(32'h0, 2, 2, 2'b11);
    do_write(32'h18, 32'hFFFF_FFFF, 4'h0, 1, 1, 1, 2'b10);
    do_read(32'h18, 1, 1, 2'b01);

    // abandon a write by reset while AWVALID waits for a READY that never comes
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1C; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
    @(negedge AXI_ACLK);
    check("mid_rst_accept", req_ready, 1'b1);
    next_cycle();
    req_valid = 1'b0;
    @(negedge AXI_ACLK);
    check("mid_rst_awvalid_pre", AXI_AWVALID, 1'b1);
    next_cycle();
    AXI_ARESET = 1'b1;
    next_cycle();
    AXI_ARESET = 1'b0;
    @(negedge AXI_ACLK);
    check("mid_rst_awvalid", AXI_AWVALID, 1'b0);
    check("mid_rst_wvalid", AXI_WVALID, 1'b0);
    check("mid_rst_bready", AXI_BREADY, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_rdata", resp_rdata, 32'h0);
    last_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      check("mid_rst_no_resp", resp_valid, 1'b0);
      next_cycle();
      @(negedge AXI_ACLK);
    end
    next_cycle();

`ifdef AXI_MASTER_TIMEOUT_EN
    do_read(32'hC, 1000, 1000, 2'b00);
    check("tmo_arvalid_after", AXI_ARVALID, 1'b0);
    do_read(32'h4, 8, 8, 2'b00);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [1:0]  rsp;
      int d1, d2, d3;
      a   = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d1  = int'($urandom_range(1, 3));
      d2  = int'($urandom_range(1, 3));
      d3  = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), d1, d2, ((d1 > d2) ? d1 : d2) + d3, rsp);
      end else begin
        do_read(a, d1, d1 + d3, rsp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns single load/store requests from the RV32I core's memory stage into AXI4-Lite transactions toward the `memory` responder and other AXI4-Lite peripherals. It handles one outstanding transaction at a time. It returns read data and error status to the core through a simple valid/ready request port and a one-cycle response pulse.

## Interface
- `AXI_AWIDTH`, 32: address width on both core and AXI side.
- `AXI_DWIDTH`, 32: data width; must be 32.
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles; used only with `AXI_MASTER_TIMEOUT_EN`.

Ports, one per line (name, direction, width, meaning):
- `AXI_ACLK` in 1: single clock.
- `AXI_ARESET` in 1: reset; synchronous, active-high.
- `req_valid` in 1: core request present.
- `req_ready` out 1: master can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in AXI_AWIDTH: byte address, passed through unmodified.
- `req_wdata` in AXI_DWIDTH: write data.
- `req_wstrb` in AXI_DWIDTH/8: byte strobes.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out AXI_DWIDTH: read data, valid with `resp_valid` on reads.
- `resp_err` out 1: bus error.
- `AXI_AWADDR` out AXI_AWIDTH; `AXI_AWVALID` out 1; `AXI_AWREADY` in 1.
- `AXI_WDATA` out AXI_DWIDTH; `AXI_WSTRB` out AXI_DWIDTH/8; `AXI_WVALID` out 1; `AXI_WREADY` in 1.
- `AXI_BRESP` in 2; `AXI_BVALID` in 1; `AXI_BREADY` out 1.
- `AXI_ARADDR` out AXI_AWIDTH; `AXI_ARVALID` out 1; `AXI_ARREADY` in 1.
- `AXI_RDATA` in AXI_DWIDTH; `AXI_RRESP` in 2; `AXI_RVALID` in 1; `AXI_RREADY` out 1.

## Operation
- **States:** IDLE, WRITE, READ.
- **Request accept:** `req_ready` = (state == IDLE). A request is accepted on `req_valid & req_ready`. Address, data and strobes are registered onto the AXI outputs at acceptance.
- **IDLE → WRITE:**
  - Assert `AXI_AWVALID`, `AXI_WVALID` and `AXI_BREADY` together.
  - AW and W complete independently. Each VALID drops the cycle after its own handshake.
  - Sticky flags `aw_done` and `w_done` track completion.
  - The B handshake (`AXI_BVALID & AXI_BREADY`) may arrive in the same cycle as the AW/W handshakes; it is accepted there.
  - The write completes only when AW, W and B have all completed.
- **IDLE → READ:**
  - Assert `AXI_ARVALID` and `AXI_RREADY` together. RREADY is high for the whole READ state, because responders may require RREADY before asserting ARREADY.
  - ARVALID drops after its handshake.
  - The R handshake may coincide with the AR handshake.
  - On the R handshake, capture `AXI_RDATA` into `resp_rdata`.
- **Completion:** pulse `resp_valid` for one cycle and return to IDLE.
  - `resp_err` = BRESP[1] for writes, RRESP[1] for reads. SLVERR and DECERR report an error; OKAY and EXOKAY do not.
  - `resp_rdata` holds its value until the next read completes. It is not updated on writes.
- **Address and strobes:** a write with `req_wstrb == 0` is still issued. Address alignment is the core's responsibility.
- **Protocol rule:** the master never drops a VALID before its handshake and never changes address, data or strobe while VALID is high.

## Timing
- **Reset values** (at the next edge with `AXI_ARESET` high):
  - All VALID and READY outputs = 0.
  - `resp_valid` = 0, `resp_err` = 0.
  - `resp_rdata`, `AXI_AWADDR`, `AXI_ARADDR`, `AXI_WDATA` = 0; `AXI_WSTRB` = 0.
  - State = IDLE.
- **Reset mid-transaction:** the transaction is abandoned. No `resp_valid` is produced, and all VALIDs drop at that edge.
- **Cycle numbering:** the request is accepted at the edge ending cycle 0. The AXI VALIDs are high in cycle 1.
- **Latency with the `memory` responder:**
  - Its READY and BVALID/RVALID are high in cycle 2.
  - `resp_valid` is high in cycle 3.
  - `req_ready` is high again in cycle 3, so back-to-back requests are accepted 3 cycles apart.
- **Latency lower bound:** with any responder, latency is at least 2 cycles from acceptance to `resp_valid`.

## Configuration
- **`AXI_MASTER_TIMEOUT_EN` defined:**
  - A counter is cleared on request accept and increments each cycle in WRITE/READ.
  - When it reaches `TIMEOUT_CYCLES` without completion, drop all VALID/READY, pulse `resp_valid` with `resp_err` = 1 (and `resp_rdata` unchanged), and return to IDLE.
  - If completion and timeout occur in the same cycle, completion wins.
- **Not defined:** no counter; the master waits indefinitely.

## Structure
- **Shared package `axi_pkg`:**
  - State enum `axi_mst_state_t`.
  - Response constants `AXI_RESP_OKAY` = 2'b00, `AXI_RESP_EXOKAY` = 2'b01, `AXI_RESP_SLVERR` = 2'b10, `AXI_RESP_DECERR` = 2'b11.
- **Sub-module:** the datapath and FSM are a single module. The watchdog is the one natural sub-module, `axi_watchdog`, instantiated only under `AXI_MASTER_TIMEOUT_EN`.

## Test plan
1. **Write then read, `memory` responder:** write 0xCAFEBABE, wstrb 0xF, to address 0x4; then read 0x4. Required: read `resp_rdata` = 0xCAFEBABE, `resp_err` = 0, `resp_valid` 3 cycles after each accept.
2. **Partial write:** memory word 0x11223344 at address 0x8; write 0x0000AA00 with wstrb 0x2; then read. Required: `resp_rdata` = 0x1122AA44.
3. **Skewed responder:** AWREADY in cycle 1, WREADY in cycle 4, BVALID in cycle 6. Required: AWVALID drops in cycle 2, WVALID drops in cycle 5, `resp_valid` in cycle 7, no VALID re-assertion.
4. **Error response:** responder returns RRESP = 2'b11 on a read. Required: `resp_err` = 1 with `resp_valid`.
5. **Reset mid-transaction:** assert `AXI_ARESET` while AWVALID is high and no READY has been given. Required: VALIDs are 0 after that edge, no `resp_valid`, `req_ready` = 1 after release.
6. **Timeout (`AXI_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8):** responder never sets ARREADY. Required: `resp_valid` with `resp_err` = 1 after 8 cycles, ARVALID = 0 afterwards.
